// File: rtl/six_bit_accumulator_if.sv
// Bundle of the accumulator's operand handshake, external adder hookup,
// result handshake and status outputs. The accumulator takes the slave
// view; the environment driving operands and hosting the adder takes the
// master view.
interface six_bit_accumulator_if #(
  parameter int WIDTH = 6
);

  // operand request side
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_data;
  logic             op_sub;
  logic             op_clr;

  // external adder/subtractor
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_sel;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;
  logic             add_cout;

  // result side
  logic             res_valid;
  logic             res_ready;

  // status
  logic [WIDTH-1:0] acc;
  logic             ovf_sticky;
  logic             cout_last;
  logic [3:0]       op_cnt;

  modport slave (
    input  op_valid, op_data, op_sub, op_clr,
    input  add_sum, add_ovf, add_cout,
    input  res_ready,
    output op_ready, add_x, add_y, add_sel,
    output res_valid, acc, ovf_sticky, cout_last, op_cnt
  );

  modport master (
    output op_valid, op_data, op_sub, op_clr,
    output add_sum, add_ovf, add_cout,
    output res_ready,
    input  op_ready, add_x, add_y, add_sel,
    input  res_valid, acc, ovf_sticky, cout_last, op_cnt
  );

endinterface

// File: rtl/six_bit_accumulator.sv
// Six-bit accumulator sequencing an external adder/subtractor.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | op_ready high; waiting for op_valid, operand captured on it
//   ST_EXEC | one cycle; external adder settles, acc/flags written at end
//   ST_HOLD | res_valid high; acc/flags frozen until res_ready
//
// The adder lives outside this block: add_x/add_y/add_sel come straight
// from registers, so the adder sees stable inputs for the whole EXEC cycle.
// In subtract mode add_cout is the "no borrow" flag and is stored as-is.
module six_bit_accumulator #(
  parameter int WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  six_bit_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opnd_q;
  logic             sub_q;
  logic             clr_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             cout_q;
  logic             cout_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic             op_ready_q;
  logic             res_valid_q;

  // Result of the op in flight: a clear loads the operand and drops all
  // flags, otherwise take the adder result and fold in its flags.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    cout_d = cout_q;
    cnt_d  = cnt_q;
    if (clr_q) begin
      acc_d  = opnd_q;
      ovf_d  = 1'b0;
      cout_d = 1'b0;
      cnt_d  = 4'd0;
    end else begin
      acc_d  = bus.add_sum;
      ovf_d  = ovf_q | bus.add_ovf;
      cout_d = bus.add_cout;
      cnt_d  = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
    end
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opnd_q      <= '0;
      sub_q       <= 1'b0;
      clr_q       <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= 4'd0;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.op_valid) begin
            opnd_q     <= bus.op_data;
            sub_q      <= bus.op_sub;
            clr_q      <= bus.op_clr;
            op_ready_q <= 1'b0;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          acc_q       <= acc_d;
          ovf_q       <= ovf_d;
          cout_q      <= cout_d;
          cnt_q       <= cnt_d;
          res_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          // op_valid is deliberately not looked at here; a request that
          // overlaps res_ready is picked up from IDLE on the next edge.
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          op_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Adder operands and status are direct register views.
  assign bus.add_x      = acc_q;
  assign bus.add_y      = opnd_q;
  assign bus.add_sel    = sub_q;
  assign bus.acc        = acc_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.cout_last  = cout_q;
  assign bus.op_cnt     = cnt_q;
  assign bus.op_ready   = op_ready_q;
  assign bus.res_valid  = res_valid_q;

endmodule

// File: tb/tb_six_bit_accumulator.sv
// Directed bench for six_bit_accumulator: hosts a behavioural adder on the
// interface, keeps a reference model, and checks each result from a
// scoreboard queue when res_valid rises.
module tb_six_bit_accumulator;

  logic clk;
  logic rst_n;

  six_bit_accumulator_if #(.WIDTH(6)) bus ();

  six_bit_accumulator #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [5:0] acc;
    logic       ovf;
    logic       cout;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [5:0] m_acc;
  logic       m_ovf;
  logic       m_cout;
  logic [3:0] m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural adder/subtractor attached to the DUT
  logic [6:0] add_full;
  always_comb begin
    add_full = '0;
    if (bus.add_sel)
      add_full = {1'b0, bus.add_x} + {1'b0, ~bus.add_y} + 7'd1;
    else
      add_full = {1'b0, bus.add_x} + {1'b0, bus.add_y};
  end
  assign bus.add_sum  = add_full[5:0];
  assign bus.add_cout = add_full[6];
  assign bus.add_ovf  = bus.add_sel
                      ? ((bus.add_x[5] != bus.add_y[5]) && (add_full[5] != bus.add_x[5]))
                      : ((bus.add_x[5] == bus.add_y[5]) && (add_full[5] != bus.add_x[5]));

  function automatic int to_s(input logic [5:0] v);
    return v[5] ? int'(v) - 64 : int'(v);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input logic [5:0] d, input logic sub, input logic clr);
    int u;
    int s;
    exp_t e;
    if (clr) begin
      m_acc = d; m_ovf = 1'b0; m_cout = 1'b0; m_cnt = 4'd0;
    end else begin
      if (sub) begin
        u = int'(m_acc) - int'(d);
        s = to_s(m_acc) - to_s(d);
        m_cout = (int'(m_acc) >= int'(d));
      end else begin
        u = int'(m_acc) + int'(d);
        s = to_s(m_acc) + to_s(d);
        m_cout = (u > 63);
      end
      m_acc = 6'((u + 64) % 64);
      m_ovf = m_ovf | ((s > 31) || (s < -32));
      m_cnt = (m_cnt == 4'd15) ? m_cnt : m_cnt + 4'd1;
    end
    e.acc = m_acc; e.ovf = m_ovf; e.cout = m_cout; e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  // Runs one operation starting at a negedge; optionally stalls the result
  // for `hold` cycles while presenting a junk request.
  task automatic do_op(input logic [5:0] d, input logic sub, input logic clr,
                       input int hold, input string tag);
    exp_t e;
    model_op(d, sub, clr);
    bus.op_data  = d;
    bus.op_sub   = sub;
    bus.op_clr   = clr;
    bus.op_valid = 1'b1;
    chk({tag, "_idle_ready"}, {7'd0, bus.op_ready}, 8'd1);
    @(posedge clk); @(negedge clk);
    bus.op_valid = 1'b0;
    chk({tag, "_exec_ready"}, {7'd0, bus.op_ready}, 8'd0);
    chk({tag, "_exec_rvalid"}, {7'd0, bus.res_valid}, 8'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_hold_rvalid"}, {7'd0, bus.res_valid}, 8'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'd0, 8'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_acc"},  {2'd0, bus.acc}, {2'd0, e.acc});
      chk({tag, "_ovf"},  {7'd0, bus.ovf_sticky}, {7'd0, e.ovf});
      chk({tag, "_cout"}, {7'd0, bus.cout_last}, {7'd0, e.cout});
      chk({tag, "_cnt"},  {4'd0, bus.op_cnt}, {4'd0, e.cnt});
    end
    if (hold > 0) begin
      bus.op_valid = 1'b1;
      bus.op_data  = ~d;
      bus.op_sub   = ~sub;
      bus.op_clr   = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); @(negedge clk);
        chk({tag, "_stall_rvalid"}, {7'd0, bus.res_valid}, 8'd1);
        chk({tag, "_stall_ready"},  {7'd0, bus.op_ready}, 8'd0);
        chk({tag, "_stall_acc"},    {2'd0, bus.acc}, {2'd0, m_acc});
        chk({tag, "_stall_addy"},   {2'd0, bus.add_y}, {2'd0, d});
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.res_ready = 1'b0;
    bus.op_valid  = 1'b0;
    chk({tag, "_back_ready"},  {7'd0, bus.op_ready}, 8'd1);
    chk({tag, "_back_rvalid"}, {7'd0, bus.res_valid}, 8'd0);
    chk({tag, "_no_capture"},  {2'd0, bus.add_y}, {2'd0, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] r;
    bus.op_valid  = 1'b0;
    bus.op_data   = '0;
    bus.op_sub    = 1'b0;
    bus.op_clr    = 1'b0;
    bus.res_ready = 1'b0;
    m_acc = '0; m_ovf = 1'b0; m_cout = 1'b0; m_cnt = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_ready",  {7'd0, bus.op_ready}, 8'd1);
    chk("rst_rvalid", {7'd0, bus.res_valid}, 8'd0);
    chk("rst_acc",    {2'd0, bus.acc}, 8'd0);
    chk("rst_addx",   {2'd0, bus.add_x}, 8'd0);
    chk("rst_addy",   {2'd0, bus.add_y}, 8'd0);
    chk("rst_addsel", {7'd0, bus.add_sel}, 8'd0);
    chk("rst_cnt",    {4'd0, bus.op_cnt}, 8'd0);

    rst_n = 1'b1;
    do_op(6'h05, 1'b0, 1'b1, 0, "clr05");
    do_op(6'h03, 1'b0, 1'b0, 0, "add03");

    do_op(6'h1F, 1'b0, 1'b1, 0, "clr1f");
    do_op(6'h01, 1'b0, 1'b0, 0, "add_ovf");
    do_op(6'h01, 1'b0, 1'b0, 0, "add_sticky");

    do_op(6'h05, 1'b0, 1'b1, 0, "clr05b");
    do_op(6'h07, 1'b1, 1'b0, 0, "sub_borrow");
    do_op(6'h07, 1'b0, 1'b1, 0, "clr07");
    do_op(6'h05, 1'b1, 1'b0, 0, "sub_noborrow");

    do_op(6'h01, 1'b0, 1'b0, 4, "stall");

    do_op(6'h00, 1'b0, 1'b1, 0, "clr00");
    for (int i = 0; i < 16; i++) begin
      r = 6'($urandom_range(0, 63));
      do_op(r, 1'($urandom_range(0, 1)), 1'b0, 0, "sat");
    end
    chk("sat_final_cnt", {4'd0, bus.op_cnt}, 8'd15);

    // reset while in EXEC
    bus.op_data  = 6'h11;
    bus.op_sub   = 1'b1;
    bus.op_clr   = 1'b0;
    bus.op_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc",    {2'd0, bus.acc}, 8'd0);
    chk("mid_rst_ovf",    {7'd0, bus.ovf_sticky}, 8'd0);
    chk("mid_rst_cout",   {7'd0, bus.cout_last}, 8'd0);
    chk("mid_rst_cnt",    {4'd0, bus.op_cnt}, 8'd0);
    chk("mid_rst_addy",   {2'd0, bus.add_y}, 8'd0);
    chk("mid_rst_addsel", {7'd0, bus.add_sel}, 8'd0);
    chk("mid_rst_ready",  {7'd0, bus.op_ready}, 8'd1);
    chk("mid_rst_rvalid", {7'd0, bus.res_valid}, 8'd0);
    @(negedge clk);
    m_acc = '0; m_ovf = 1'b0; m_cout = 1'b0; m_cnt = '0;
    sb_q.delete();
    rst_n = 1'b1;
    do_op(6'h2A, 1'b0, 1'b0, 0, "post_rst_add");
    do_op(6'h2A, 1'b1, 1'b1, 0, "post_rst_clr");

    chk("sb_drained", 8'(sb_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
